mem_access_ctrl: RTL
====================

# mem_access_ctrl

Bus initiator for the 16-bit processor's 256×16 data memory. It accepts load, store, block-copy and block-fill requests from the core over a valid/ready handshake and sequences the memory's `memread`/`memwrite`/`address`/`data_in` strobes. It captures `data_out` and returns a one-cycle response pulse on completion. It sits between the execute stage and the data memory; the memory itself is unchanged.

## Interface
- `ADDR_W`, 8: memory address width; address space is 2^ADDR_W words.
- `DATA_W`, 16: word width.
- `clk`  in  1  sole clock; all flops update on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a transfer occurs when `req_valid && req_ready` at a rising edge.
- `req_op`  in  2  00 LOAD, 01 STORE, 10 COPY, 11 FILL.
- `req_addr`  in  ADDR_W  LOAD/STORE address; COPY source; FILL start address.
- `req_dst`  in  ADDR_W  COPY destination; ignored otherwise.
- `req_len`  in  ADDR_W  COPY/FILL word count, 0–255; ignored for LOAD/STORE.
- `req_wdata`  in  DATA_W  STORE/FILL data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  DATA_W  last LOAD result; holds until the next LOAD completes.
- `busy`  out  1  high in every state except IDLE.
- `mem_read`  out  1  to memory `memread`.
- `mem_write`  out  1  to memory `memwrite`.
- `mem_addr`  out  ADDR_W  to memory `address`.
- `mem_wdata`  out  DATA_W  to memory `data_in`.
- `mem_rdata`  in  DATA_W  from memory `data_out`; combinationally valid in a `mem_read` cycle.

## Operation
- The FSM states are IDLE, LOAD, STORE, CP_RD, CP_WR, FILL, DONE.
- Request fields (op, addr, dst, len, wdata) are latched at the accept edge. Later input changes have no effect.
- **LOAD:** one cycle with `mem_read=1` and `mem_addr=addr`. `mem_rdata` is captured into `rsp_rdata` at the end of that cycle. Next state is DONE.
- **STORE:** one cycle with `mem_write=1`, `mem_addr=addr`, `mem_wdata=wdata`. Next state is DONE.
- **COPY:** for i = 0..len-1, ascending:
  - CP_RD: `mem_read`, `addr=src+i`; data is captured into an internal word buffer.
  - CP_WR: `mem_write`, `addr=dst+i`, `wdata=buffer`.
  - After the last CP_WR, next state is DONE. `rsp_rdata` is not modified.
- **FILL:** for i = 0..len-1, one FILL cycle each with `mem_write`, `addr=start+i`, `wdata=wdata`. Next state is DONE.
- **len = 0** (COPY/FILL): go directly from accept to DONE; no memory strobes are issued.
- **DONE:** `rsp_valid=1` for exactly one cycle, then IDLE.
- All address arithmetic is modulo 2^ADDR_W; 0xFF+1 wraps to 0x00. The remaining count is a down-counter; no underflow past 0.
- **Overlapping COPY:** strictly ascending word-by-word. With dst > src inside the range, already-written words are re-read. This is defined behaviour, not an error.
- `mem_read` and `mem_write` are never high in the same cycle.
- When neither strobe is high, `mem_addr` and `mem_wdata` are 0.
- All `mem_*` outputs come directly from flops, because the memory is level-sensitive and must see no glitches.
- `req_valid` while busy: ignored (`req_ready=0`); the request is not queued.

## Timing
- Reset values: `req_ready=1` (in IDLE after reset); `busy=0`; `rsp_valid=0`; `rsp_rdata=0`; `mem_read=0`; `mem_write=0`; `mem_addr=0`; `mem_wdata=0`.
- Accept at edge N:
  - LOAD/STORE: strobe during cycle N+1; `rsp_valid` during N+2. Next accept is possible at edge N+3.
  - COPY: strobes in cycles N+1 … N+2·len; `rsp_valid` at N+2·len+1.
  - FILL: writes in cycles N+1 … N+len; `rsp_valid` at N+len+1.
  - len = 0: `rsp_valid` at N+1.
- `rsp_valid` has no backpressure; the consumer must take it in the pulse cycle.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronously) and the FSM enters IDLE. Words already written stay written; no response is issued for the aborted request.

## Structure
- Package `mem_access_pkg`: op encodings (`OP_LOAD`, `OP_STORE`, `OP_COPY`, `OP_FILL`) and the state enum. The same op codes are reused by the control unit.
- One sub-module, `mem_addr_gen`, holds the source and destination pointers plus the remaining-count down-counter, with load, step and `last` outputs.
- The FSM and output registers stay in `mem_access_ctrl`.

## Test plan
- **Reset:** assert `rst` mid-cycle → all outputs at reset values without waiting for a clock edge. After release, `req_ready=1`.
- **STORE then LOAD:** STORE 0xBEEF to 0x10, then LOAD 0x10 → one `mem_write` cycle with addr 0x10 and data 0xBEEF. `rsp_valid` 2 cycles after each accept, and `rsp_rdata=0xBEEF`.
- **COPY with wrap:** preload 0xFE=0x1111, 0xFF=0x2222, 0x00=0x3333; COPY src 0xFE, dst 0x20, len 3 → 0x20..0x22 hold 0x1111/0x2222/0x3333. Exactly 6 alternating strobe cycles; `rsp_valid` at N+7.
- **FILL with len 0:** FILL len 0 → `rsp_valid` at N+1, no strobes. Then FILL 0x00A5, addr 0x80, len 4 → 0x80..0x83 = 0x00A5; `rsp_valid` at N+5.
- **Busy rejection:** drive `req_valid` during an active COPY with a different op → `req_ready=0`, no effect, no extra `rsp_valid`.
- **Reset mid-COPY:** assert `rst` after the 2nd CP_WR of a len-5 copy → strobes drop immediately, no `rsp_valid`. Exactly the first 2 destination words are written; the next request is accepted normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the data-memory access controller:
//   - memory geometry defaults (address and word width)
//   - request op encodings, also used by the control unit
//   - controller FSM state encoding
package mem_access_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_COPY  = 2'b10,
    OP_FILL  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    CP_RD,
    CP_WR,
    FILL,
    DONE
  } state_e;

endpackage

// File: rtl/mem_addr_gen.sv
// mem_addr_gen
// Block-transfer pointers for COPY/FILL: source (also FILL start),
// destination, and a remaining-word down-counter.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            capture load_src/load_dst/load_len
//   step            advance both pointers, decrement count (saturates at 0)
//   load_src/dst/len  values captured on load
//   dst             current destination pointer
//   src_plus        source pointer + 1 (modulo 2^ADDR_W), the next read/fill address
//   last            current word is the final one of the block
module mem_addr_gen
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_src,
  input  logic [ADDR_W-1:0] load_dst,
  input  logic [ADDR_W-1:0] load_len,
  output logic [ADDR_W-1:0] dst,
  output logic [ADDR_W-1:0] src_plus,
  output logic              last
);

  logic [ADDR_W-1:0] src_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [ADDR_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_reg   <= '0;
      dst_reg   <= '0;
      count_reg <= '0;
    end else if (load) begin
      src_reg   <= load_src;
      dst_reg   <= load_dst;
      count_reg <= load_len;
    end else if (step) begin
      src_reg <= src_reg + ADDR_W'(1);
      dst_reg <= dst_reg + ADDR_W'(1);
      if (count_reg != '0) begin
        count_reg <= count_reg - ADDR_W'(1);
      end
    end
  end

  assign dst      = dst_reg;
  assign src_plus = src_reg + ADDR_W'(1);
  assign last     = (count_reg == ADDR_W'(1));

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Bus initiator for the 256x16 data memory. Accepts LOAD/STORE/COPY/FILL
// requests on a valid/ready handshake and sequences the memory strobes.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_op/addr/dst/len/wdata request fields, latched at accept
//   rsp_valid                one-cycle completion pulse
//   rsp_rdata                last LOAD result, held until the next LOAD
//   busy                     high outside IDLE
//   mem_read/mem_write/mem_addr/mem_wdata  registered memory strobes
//   mem_rdata                memory read data, valid in a mem_read cycle
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [ADDR_W-1:0] req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_reg, state_next;
  logic [DATA_W-1:0] wdata_reg;
  logic              mem_read_next, mem_write_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next;
  logic              ag_load, ag_step, ag_last;
  logic [ADDR_W-1:0] dst_ptr, src_plus;

  mem_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (ag_load),
    .step     (ag_step),
    .load_src (req_addr),
    .load_dst (req_dst),
    .load_len (req_len),
    .dst      (dst_ptr),
    .src_plus (src_plus),
    .last     (ag_last)
  );

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign rsp_valid = (state_reg == DONE);

  // The strobes are flops, so the values for the coming cycle are decided
  // here alongside the next state. Op and length only steer the branch at
  // accept; the pointers and count live in mem_addr_gen.
  always_comb begin
    state_next     = state_reg;
    ag_load        = 1'b0;
    ag_step        = 1'b0;
    mem_read_next  = 1'b0;
    mem_write_next = 1'b0;
    mem_addr_next  = '0;
    mem_wdata_next = '0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          ag_load = 1'b1;
          case (op_e'(req_op))
            OP_LOAD: begin
              state_next    = LOAD;
              mem_read_next = 1'b1;
              mem_addr_next = req_addr;
            end
            OP_STORE: begin
              state_next     = STORE;
              mem_write_next = 1'b1;
              mem_addr_next  = req_addr;
              mem_wdata_next = req_wdata;
            end
            OP_COPY: begin
              if (req_len == '0) begin
                state_next = DONE;
              end else begin
                state_next    = CP_RD;
                mem_read_next = 1'b1;
                mem_addr_next = req_addr;
              end
            end
            default: begin
              if (req_len == '0) begin
                state_next = DONE;
              end else begin
                state_next     = FILL;
                mem_write_next = 1'b1;
                mem_addr_next  = req_addr;
                mem_wdata_next = req_wdata;
              end
            end
          endcase
        end
      end
      LOAD, STORE: state_next = DONE;
      CP_RD: begin
        // The mem_wdata flop doubles as the copy word buffer.
        state_next     = CP_WR;
        mem_write_next = 1'b1;
        mem_addr_next  = dst_ptr;
        mem_wdata_next = mem_rdata;
      end
      CP_WR: begin
        ag_step = 1'b1;
        if (ag_last) begin
          state_next = DONE;
        end else begin
          state_next    = CP_RD;
          mem_read_next = 1'b1;
          mem_addr_next = src_plus;
        end
      end
      FILL: begin
        ag_step = 1'b1;
        if (ag_last) begin
          state_next = DONE;
        end else begin
          state_next     = FILL;
          mem_write_next = 1'b1;
          mem_addr_next  = src_plus;
          mem_wdata_next = wdata_reg;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      wdata_reg <= '0;
      rsp_rdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_reg <= state_next;
      mem_read  <= mem_read_next;
      mem_write <= mem_write_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      if (req_valid && req_ready) begin
        wdata_reg <= req_wdata;
      end
      if (state_reg == LOAD) begin
        rsp_rdata <= mem_rdata;
      end
    end
  end

endmodule
